// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift engine.
// Opcodes, FSM states and an opcode classifier.
package univ_shift_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD  = 3'd0,
    OP_SHL   = 3'd1,
    OP_LOAD  = 3'd2,
    OP_SHR   = 3'd3,
    OP_ROL   = 3'd4,
    OP_ROR   = 3'd5,
    OP_ASR   = 3'd6,
    OP_CLEAR = 3'd7
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } shift_state_e;

  function automatic logic is_shift(
    input shift_op_e op
  );
    return (op == OP_SHL) || (op == OP_SHR) ||
           (op == OP_ROL) || (op == OP_ROR) ||
           (op == OP_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_step.sv
// One-position next value of the shift register.
// Parallel ops (LOAD) are resolved by the caller.
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  shift_op_e        op,
  input  logic [WIDTH-1:0] q,
  input  logic             s_in_lsb,
  input  logic             s_in_msb,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = q;
    unique case (op)
      OP_HOLD:  nxt = q;
      OP_SHL:   nxt = {q[WIDTH-2:0], s_in_lsb};
      OP_LOAD:  nxt = q;
      OP_SHR:   nxt = {s_in_msb, q[WIDTH-1:1]};
      OP_ROL:   nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:   nxt = {q[0], q[WIDTH-1:1]};
      OP_ASR:   nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_CLEAR: nxt = '0;
      default:  nxt = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_engine.sv
// Universal shift register with command handshake.
// Define UNIV_SHIFT_BARREL_EN for single-cycle multi-bit shifts.
module univ_shift_engine
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] d_in,
  input  logic             s_in_lsb,
  input  logic             s_in_msb,
  output logic [WIDTH-1:0] q,
  output logic             s_out_msb,
  output logic             s_out_lsb,
  output logic             busy,
  output logic             done
);

  shift_state_e     state;
  shift_op_e        op_r;
  shift_op_e        op_in;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] step_q;

  assign op_in     = shift_op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE) && ena;
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign s_out_msb = q[WIDTH-1];
  assign s_out_lsb = q[0];

  univ_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op       (op_r),
    .q        (q),
    .s_in_lsb (s_in_lsb),
    .s_in_msb (s_in_msb),
    .nxt      (step_q)
  );

`ifdef UNIV_SHIFT_BARREL_EN
  // Rotates wrap modulo WIDTH; shifts saturate to the fill bit.
  function automatic logic [WIDTH-1:0] barrel(
    input shift_op_e        op,
    input logic [WIDTH-1:0] v,
    input logic [AMT_W-1:0] k,
    input logic             fl,
    input logic             fm
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] ones;
    logic [AMT_W-1:0] kr;
    ones = '1;
    kr   = AMT_W'(k % AMT_W'(WIDTH));
    r    = v;
    unique case (op)
      OP_SHL:
        r = (k >= AMT_W'(WIDTH)) ? {WIDTH{fl}} :
            (v << k) | ({WIDTH{fl}} & ~(ones << k));
      OP_SHR:
        r = (k >= AMT_W'(WIDTH)) ? {WIDTH{fm}} :
            (v >> k) | ({WIDTH{fm}} & ~(ones >> k));
      OP_ROL:
        r = (v << kr) | (v >> (AMT_W'(WIDTH) - kr));
      OP_ROR:
        r = (v >> kr) | (v << (AMT_W'(WIDTH) - kr));
      OP_ASR:
        r = WIDTH'($signed(v) >>> k);
      default: r = step_q;
    endcase
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      state <= ST_IDLE;
      cnt   <= '0;
      op_r  <= OP_HOLD;
    end else if (ena) begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r <= op_in;
            unique case (1'b1)
              (op_in == OP_LOAD): begin
                q     <= d_in;
                state <= ST_DONE;
              end
              (op_in == OP_CLEAR): begin
                q     <= '0;
                state <= ST_DONE;
              end
              is_shift(op_in): begin
                cnt   <= cmd_amt;
                state <= (cmd_amt == '0) ? ST_DONE : ST_RUN;
              end
              default: state <= ST_DONE;
            endcase
          end
        end
        ST_RUN: begin
`ifdef UNIV_SHIFT_BARREL_EN
          q     <= barrel(op_r, q, cnt, s_in_lsb, s_in_msb);
          cnt   <= '0;
          state <= ST_DONE;
`else
          q   <= step_q;
          cnt <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) state <= ST_DONE;
`endif
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_engine.sv
// Self-checking bench for univ_shift_engine (WIDTH=8).
// Reference model works on integer arithmetic per opcode.
module tb_univ_shift_engine;

  localparam int W = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_amt = '0;
  logic [W-1:0]  d_in = '0;
  logic          s_in_lsb = 1'b0;
  logic          s_in_msb = 1'b0;
  logic [W-1:0]  q;
  logic          s_out_msb;
  logic          s_out_lsb;
  logic          busy;
  logic          done;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] mq = '0;

  univ_shift_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .d_in(d_in),
    .s_in_lsb(s_in_lsb), .s_in_msb(s_in_msb),
    .q(q), .s_out_msb(s_out_msb), .s_out_lsb(s_out_lsb),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One step of an 8-bit register expressed with integer arithmetic.
  function automatic logic [W-1:0] mstep(
    input int op, input logic [W-1:0] v, input bit fl, input bit fm
  );
    int x;
    x = int'(v);
    case (op)
      1: x = (x * 2) % 256 + int'(fl);
      3: x = x / 2 + int'(fm) * 128;
      4: x = (x * 2) % 256 + x / 128;
      5: x = x / 2 + (x % 2) * 128;
      6: x = x / 2 + (x / 128) * 128;
      default: x = int'(v);
    endcase
    return W'(x);
  endfunction

  function automatic logic [W-1:0] mfinal(
    input int op, input int k, input logic [W-1:0] v,
    input logic [W-1:0] d, input bit fl, input bit fm
  );
    logic [W-1:0] r;
    r = v;
    if (op == 2) r = d;
    else if (op == 7) r = '0;
    else for (int i = 0; i < k; i++) r = mstep(op, r, fl, fm);
    return r;
  endfunction

  task automatic issue(input int op, input int amt, input logic [W-1:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      compared++;
      mismatched++;
      $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = 3'(op);
    cmd_amt = AW'(amt);
    d_in = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    compared++;
    if (q !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_q: got %h want 00", q);
    end
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    mq = '0;
  endtask

  task automatic test_load;
    @(negedge clk);
    issue(2, 0, 8'hA5);
    mq = 8'hA5;
    compared++;
    if (q !== 8'hA5 || done !== 1'b1 || cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL load_e0: q=%h done=%b rdy=%b want a5 1 0",
               q, done, cmd_ready);
    end
    @(posedge clk);
    #1;
    compared++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL load_e1: done=%b rdy=%b want 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_rol;
    logic [W-1:0] exp_seq [3];
    int nb;
    exp_seq[0] = 8'h4B;
    exp_seq[1] = 8'h96;
    exp_seq[2] = 8'h2D;
    nb = 0;
    issue(4, 3, 8'h00);
`ifndef UNIV_SHIFT_BARREL_EN
    for (int i = 0; i < 3; i++) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      compared++;
      if (q !== exp_seq[i]) begin
        mismatched++;
        $display("FAIL rol_step%0d: got %h want %h", i, q, exp_seq[i]);
      end
    end
    compared++;
    if (nb != 3 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL rol_timing: busy_cycles=%0d done=%b want 3 1", nb, done);
    end
`else
    @(posedge clk);
    #1;
    compared++;
    if (q !== 8'h2D || done !== 1'b1) begin
      mismatched++;
      $display("FAIL rol_barrel: q=%h done=%b want 2d 1", q, done);
    end
`endif
    mq = 8'h2D;
    @(posedge clk);
    #1;
  endtask

  task automatic test_asr;
    int n;
    issue(2, 0, 8'h96);
    s_in_msb = 1'b0;
    s_in_lsb = 1'b1;
    issue(6, 2, 8'hFF);
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    compared++;
    if (q !== 8'hE5 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL asr_result: q=%h done=%b want e5 1", q, done);
    end
    mq = 8'hE5;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall;
    int n;
    issue(7, 0, 8'hFF);
    @(posedge clk);
    #1;
    s_in_lsb = 1'b1;
    issue(1, 4, 8'h00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ena = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if (q !== 8'h03 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold%0d: q=%h busy=%b rdy=%b want 03 1 0",
                 i, q, busy, cmd_ready);
      end
    end
    ena = 1'b1;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    compared++;
    if (q !== 8'h0F || n != 2) begin
      mismatched++;
      $display("FAIL stall_result: q=%h cycles=%0d want 0f 2", q, n);
    end
    ena = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if (done !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_done%0d: done=%b want 1", i, done);
      end
    end
    ena = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_release: done=%b rdy=%b want 0 1", done, cmd_ready);
    end
    mq = 8'h0F;
  endtask

  task automatic test_abort;
    issue(2, 0, 8'h81);
    issue(5, 5, 8'h00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_reset: q=%h busy=%b done=%b want 00 0 0",
               q, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL abort_quiet%0d: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    issue(2, 0, 8'h3C);
    compared++;
    if (q !== 8'h3C || done !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_reload: q=%h done=%b want 3c 1", q, done);
    end
    mq = 8'h3C;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignored;
    int n;
    s_in_lsb = 1'b0;
    issue(1, 3, 8'h00);
    cmd_valid = 1'b1;
    cmd_op = 3'd2;
    d_in = 8'hFF;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    mq = mfinal(1, 3, mq, 8'h00, 1'b0, 1'b0);
    compared++;
    if (q !== mq) begin
      mismatched++;
      $display("FAIL ignored_cmd: q=%h want %h", q, mq);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    int op, k, n, nb, exp_nb;
    logic [W-1:0] d;
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 7));
      k = int'($urandom_range(0, 15));
      d = W'($urandom);
      s_in_lsb = 1'($urandom);
      s_in_msb = 1'($urandom);
      mq = mfinal(op, k, mq, d, s_in_lsb, s_in_msb);
      exp_nb = 0;
      if (op != 0 && op != 2 && op != 7) exp_nb = k;
`ifdef UNIV_SHIFT_BARREL_EN
      if (exp_nb > 1) exp_nb = 1;
`endif
      issue(op, k, d);
      n = 0;
      nb = 0;
      while (!done && n < 50) begin
        if (busy) nb++;
        @(posedge clk);
        #1;
        n++;
      end
      compared++;
      if (q !== mq || nb != exp_nb || s_out_msb !== mq[W-1] ||
          s_out_lsb !== mq[0]) begin
        mismatched++;
        $display("FAIL random%0d op=%0d k=%0d: q=%h busy=%0d want %h %0d",
                 t, op, k, q, nb, mq, exp_nb);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_rol;
    test_asr;
    test_stall;
    test_abort;
    test_ignored;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/univ_shift_engine.md
# univ_shift_engine

Parametrised universal shift register with a command handshake, the successor of the 8-bit HOLD/SHIFT/LOAD register. It runs one multi-step operation per command: load, clear, logical shift, rotate or arithmetic shift by a programmable amount, one bit position per cycle. Completion is signalled with a `done` pulse. It sits behind the pin-level wrapper, which maps pins onto the command, data and serial ports.

## Interface
- `WIDTH`, default 8: register width, ≥ 2. Localparam `AMT_W = $clog2(WIDTH)+1`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: global enable; when low, all state freezes.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: `(state==IDLE) & ena`.
- `cmd_op` in 3: operation code.
- `cmd_amt` in AMT_W: step count, 0 to 2^AMT_W−1.
- `d_in` in WIDTH: parallel load data.
- `s_in_lsb` in 1: serial fill bit for SHL.
- `s_in_msb` in 1: serial fill bit for SHR.
- `q` out WIDTH: register contents.
- `s_out_msb` out 1: `q[WIDTH-1]`, combinational.
- `s_out_lsb` out 1: `q[0]`, combinational.
- `busy` out 1: high in state RUN.
- `done` out 1: high in state DONE.

## Operation
- Opcodes:
  - 0 HOLD.
  - 1 SHL: `{q[W-2:0], s_in_lsb}`.
  - 2 LOAD: `d_in`.
  - 3 SHR: `{s_in_msb, q[W-1:1]}`.
  - 4 ROL.
  - 5 ROR.
  - 6 ASR: `{q[W-1], q[W-1:1]}`; serial inputs ignored.
  - 7 CLEAR.
- FSM states: IDLE, RUN, DONE.
- Accept occurs on an edge with `cmd_valid & cmd_ready`. On that edge the engine latches `cmd_op`.
  - HOLD, LOAD, CLEAR: result written to `q` on the accept edge; next state DONE. `cmd_amt` is ignored.
  - Shift or rotate with `cmd_amt==0`: `q` unchanged; next state DONE.
  - Shift or rotate with `cmd_amt==k≥1`: counter loaded with k; next state RUN.
- RUN: each enabled edge applies one step and decrements the counter. The step that brings the counter to 0 moves the FSM to DONE.
- Serial inputs are sampled live at each step edge.
- DONE lasts exactly one enabled cycle, then IDLE.
- k larger than WIDTH is legal and is executed literally (k steps). For example, ROL by WIDTH returns the original value.
- `cmd_valid` while not ready is ignored; there is no queueing.
- `ena` low: no accept, no step, no state change. `done` and `busy` hold their values.
- Reset values: `q=0`, state IDLE, counter 0, `busy=0`, `done=0`. `cmd_ready=1` once `rst_n=1` and `ena=1`.
- Reset mid-operation aborts immediately (asynchronous). No `done` is produced for the aborted command.

## Timing
- Accept at edge E0. A shift of k runs steps on E1..Ek. `done` is high for the cycle after Ek. IDLE is reached at E(k+1).
- `busy` is high for k cycles.
- LOAD, CLEAR, HOLD and k=0 shifts: `q` updates at E0; `done` is high in the following cycle.
- Minimum command spacing: 2 cycles for single-cycle ops, k+2 cycles for shifts.
- `q` and `s_out_*` are registered or derived directly from the register, with no input-to-output combinational path.

## Configuration
- `UNIV_SHIFT_BARREL_EN` defined: a shift with k≥1 spends exactly one RUN cycle. The full k-position result, with k reduced modulo WIDTH for rotates, is applied at E1. For SHL/SHR with k≥WIDTH, every bit equals the fill bit. Fill bits are all the serial input sampled at E1. `busy` is high for 1 cycle.
- Undefined (default): one bit per cycle as above.
- Results are identical in both builds whenever the serial inputs are constant during the operation.

## Structure
- Package `univ_shift_pkg`:
  - op enum `shift_op_e` with the eight codes;
  - FSM enum `shift_state_e`;
  - `OP_W = 3`.
- Sub-module `univ_shift_step`: combinational single-step next-value function of (`op`, `q`, `s_in_lsb`, `s_in_msb`). It is instantiated once. The barrel build adds a separate multi-position function in the top module.

## Test plan
- Reset and enable: assert `rst_n=0` mid-stream → `q=0x00`, `busy=0`, `done=0`. Release with `ena=1` → `cmd_ready=1`.
- LOAD `0xA5` → `q=0xA5` after E0. `done` is high for exactly 1 cycle. `cmd_ready` is low for 1 cycle.
- ROL k=3 from `0xA5` → `q` sequence `0x4B`, `0x96`, `0x2D`. `busy` is high for 3 cycles. `done` is high in the 4th cycle. In the barrel build, `0x2D` appears at E1.
- ASR k=2 from `0x96` → `0xCB` then `0xE5`. With `s_in_msb=0` held, the result is still `0xE5`.
- SHL k=4 from `0x00` with `s_in_lsb=1`, `ena` low for 2 cycles after the second step → `q` holds `0x03` during the stall, then reaches `0x0F`. `done` is held during any stall.
- ROR k=5 from `0x81`, reset pulsed after 2 steps → `q=0x00` immediately, no `done`. A new LOAD `0x3C` is then accepted normally.
